// File: rtl/cfa_pkg.sv
// Shared widths, the full-scale pixel value and the lane-slicing helper for the CFA R/B reconstruction datapath.
package cfa_pkg;

    localparam int CFA_PIXEL_W = 12;
    localparam int CFA_DIFF_W  = 10;
    localparam int PIX_MAX     = (1 << CFA_PIXEL_W) - 1;

    // LSB position of a lane inside a packed multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/cfa_sat_sub.sv
// One lane channel: S1 registers G minus the sign-extended difference, S2 clamps to [0, 2^PIXEL_W-1] and flags saturation.
// Latency 2 (one register per stage); each stage loads only on its enable, so a stalled pipe holds its contents.
module cfa_sat_sub
    import cfa_pkg::*;
#(
    parameter int PIXEL_W = CFA_PIXEL_W,
    parameter int DIFF_W  = CFA_DIFF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s1_en_i,
    input  logic               s2_en_i,
    input  logic [PIXEL_W-1:0] g_i,
    input  logic [DIFF_W-1:0]  diff_i,
    output logic [PIXEL_W-1:0] pix_o,
    output logic               lo_o,
    output logic               hi_o
);

    localparam int EXT_W = PIXEL_W + 2;

    logic [EXT_W-1:0]   diff_q, diff_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;
    logic               lo_q, lo_d, hi_q, hi_d;

    // Two guard bits keep both G+512 overflow and G-511 underflow representable.
    always_comb begin
        diff_d = diff_q;
        if (s1_en_i) begin
            diff_d = {2'b00, g_i} - {{(EXT_W-DIFF_W){diff_i[DIFF_W-1]}}, diff_i};
        end
        lo_d  = lo_q;
        hi_d  = hi_q;
        pix_d = pix_q;
        if (s2_en_i) begin
            lo_d  = diff_q[EXT_W-1];
            hi_d  = !diff_q[EXT_W-1] && (|diff_q[EXT_W-2:PIXEL_W]);
            pix_d = diff_q[PIXEL_W-1:0];
            if (diff_q[EXT_W-1]) begin
                pix_d = '0;
            end else if (|diff_q[EXT_W-2:PIXEL_W]) begin
                pix_d = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '0;
            pix_q  <= '0;
            lo_q   <= 1'b0;
            hi_q   <= 1'b0;
        end else begin
            diff_q <= diff_d;
            pix_q  <= pix_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
        end
    end

    assign pix_o = pix_q;
    assign lo_o  = lo_q;
    assign hi_o  = hi_q;

endmodule

// File: rtl/cfa_rb_recon.sv
// Multi-lane R/B reconstruction R = clamp(G-(G-R)), B = clamp(G-(G-B)); optional saturation counters under CFA_RB_SAT_CNT_EN.
// Latency 2 cycles, 1 beat/cycle; both stages advance only when !out_valid || out_ready, and in_ready follows that enable.
module cfa_rb_recon
    import cfa_pkg::*;
#(
    parameter int PIXEL_W = CFA_PIXEL_W,
    parameter int DIFF_W  = CFA_DIFF_W,
    parameter int LANES   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*PIXEL_W-1:0] in_g,
    input  logic [LANES*DIFF_W-1:0]  in_gmr,
    input  logic [LANES*DIFF_W-1:0]  in_gmb,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*PIXEL_W-1:0] out_r,
    output logic [LANES*PIXEL_W-1:0] out_b,
    output logic [LANES*PIXEL_W-1:0] out_g,
    output logic                     out_last
`ifdef CFA_RB_SAT_CNT_EN
    ,
    input  logic                     sat_clr,
    output logic [CNT_W-1:0]         sat_lo_cnt,
    output logic [CNT_W-1:0]         sat_hi_cnt
`endif
);

    logic en, accept, s2_load;
    logic s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
    logic s1_last_q, s1_last_d, out_last_q, out_last_d;
    logic [LANES*PIXEL_W-1:0] s1_g_q, s1_g_d, out_g_q, out_g_d;
    logic [2*LANES-1:0] sat_lo, sat_hi;

    always_comb begin
        en         = !out_vld_q || out_ready;
        accept     = in_valid && en;
        s2_load    = en && s1_vld_q;
        s1_vld_d   = en ? in_valid : s1_vld_q;
        out_vld_d  = en ? s1_vld_q : out_vld_q;
        s1_g_d     = accept ? in_g : s1_g_q;
        s1_last_d  = accept ? in_last : s1_last_q;
        out_g_d    = s2_load ? s1_g_q : out_g_q;
        out_last_d = s2_load ? s1_last_q : out_last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            s1_g_q     <= '0;
            out_g_q    <= '0;
            s1_last_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            out_vld_q  <= out_vld_d;
            s1_g_q     <= s1_g_d;
            out_g_q    <= out_g_d;
            s1_last_q  <= s1_last_d;
            out_last_q <= out_last_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_vld_q;
    assign out_g     = out_g_q;
    assign out_last  = out_last_q;

    // Flag index 2*l is lane l's R channel, 2*l+1 its B channel.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cfa_sat_sub #(.PIXEL_W(PIXEL_W), .DIFF_W(DIFF_W)) u_r (
            .clk     (clk),
            .rst     (rst),
            .s1_en_i (accept),
            .s2_en_i (s2_load),
            .g_i     (in_g[lane_lsb(l, PIXEL_W) +: PIXEL_W]),
            .diff_i  (in_gmr[lane_lsb(l, DIFF_W) +: DIFF_W]),
            .pix_o   (out_r[lane_lsb(l, PIXEL_W) +: PIXEL_W]),
            .lo_o    (sat_lo[2*l]),
            .hi_o    (sat_hi[2*l])
        );
        cfa_sat_sub #(.PIXEL_W(PIXEL_W), .DIFF_W(DIFF_W)) u_b (
            .clk     (clk),
            .rst     (rst),
            .s1_en_i (accept),
            .s2_en_i (s2_load),
            .g_i     (in_g[lane_lsb(l, PIXEL_W) +: PIXEL_W]),
            .diff_i  (in_gmb[lane_lsb(l, DIFF_W) +: DIFF_W]),
            .pix_o   (out_b[lane_lsb(l, PIXEL_W) +: PIXEL_W]),
            .lo_o    (sat_lo[2*l+1]),
            .hi_o    (sat_hi[2*l+1])
        );
    end

`ifdef CFA_RB_SAT_CNT_EN
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d, hi_cnt_q, hi_cnt_d;
    logic [CNT_W:0]   lo_sum, hi_sum;

    // One extra sum bit detects overflow so the counters stick at all-ones.
    always_comb begin
        lo_sum = {1'b0, lo_cnt_q};
        hi_sum = {1'b0, hi_cnt_q};
        if (out_vld_q && out_ready) begin
            for (int i = 0; i < 2*LANES; i++) begin
                lo_sum = lo_sum + (CNT_W+1)'(sat_lo[i]);
                hi_sum = hi_sum + (CNT_W+1)'(sat_hi[i]);
            end
        end
        lo_cnt_d = lo_sum[CNT_W] ? '1 : lo_sum[CNT_W-1:0];
        hi_cnt_d = hi_sum[CNT_W] ? '1 : hi_sum[CNT_W-1:0];
        if (sat_clr) begin
            lo_cnt_d = '0;
            hi_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_cnt_q <= '0;
            hi_cnt_q <= '0;
        end else begin
            lo_cnt_q <= lo_cnt_d;
            hi_cnt_q <= hi_cnt_d;
        end
    end

    assign sat_lo_cnt = lo_cnt_q;
    assign sat_hi_cnt = hi_cnt_q;
`else
    logic unused_sat;
    localparam int unused_cnt_w = CNT_W;
    assign unused_sat = ^{sat_lo, sat_hi};
`endif

endmodule

// File: tb/tb_cfa_rb_recon.sv
// Randomized and directed bench for cfa_rb_recon against a queue-based reference model of the reconstruction rules.
module tb_cfa_rb_recon;

    localparam int PW = 12;
    localparam int DW = 10;
    localparam int L  = 2;
    localparam int CW = 16;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [L*PW-1:0] in_g, out_r, out_b, out_g;
    logic [L*DW-1:0] in_gmr, in_gmb;
`ifdef CFA_RB_SAT_CNT_EN
    logic sat_clr;
    logic [CW-1:0] sat_lo_cnt, sat_hi_cnt;
`endif

    cfa_rb_recon #(.PIXEL_W(PW), .DIFF_W(DW), .LANES(L), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_g      (in_g),
        .in_gmr    (in_gmr),
        .in_gmb    (in_gmb),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_b     (out_b),
        .out_g     (out_g),
        .out_last  (out_last)
`ifdef CFA_RB_SAT_CNT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_lo_cnt(sat_lo_cnt),
        .sat_hi_cnt(sat_hi_cnt)
`endif
    );

    typedef struct {
        logic [L*PW-1:0] r, b, g;
        logic            last;
        int              cyc;
        int              nlo, nhi;
    } beat_t;

    beat_t exp_q[$];
    int  n_chk = 0, n_fail = 0, cyc = 0, n_out = 0;
    bit  lat_chk = 1'b0, saw_block = 1'b0, stalled = 1'b0;
    logic [L*PW-1:0] hold_r, hold_b, hold_g;
    logic hold_last;
    int unsigned m_lo = 0, m_hi = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v < 0) return 0;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Reference model: enqueue on accept, dequeue and compare on transfer.
    always @(negedge clk) begin
        beat_t e;
        int g, vr, vb;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_r", out_r, hold_r);
                check_eq("hold_b", out_b, hold_b);
                check_eq("hold_g", out_g, hold_g);
                check_eq("hold_last", out_last, hold_last);
            end
            check_eq("in_ready", in_ready, !(out_valid && !out_ready));
            if (!in_ready) saw_block = 1'b1;
            if (exp_q.size() == 0) check_eq("idle_valid", out_valid, 0);
            if (lat_chk) check_eq("vld_pattern", out_valid, exp_q.size() > 0 && (cyc - exp_q[0].cyc) >= 2);
`ifdef CFA_RB_SAT_CNT_EN
            check_eq("sat_lo_cnt", sat_lo_cnt, m_lo);
            check_eq("sat_hi_cnt", sat_hi_cnt, m_hi);
`endif
            e.nlo = 0;
            e.nhi = 0;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("out_r", out_r, e.r);
                check_eq("out_b", out_b, e.b);
                check_eq("out_g", out_g, e.g);
                check_eq("out_last", out_last, e.last);
                if (lat_chk) check_eq("latency", cyc - e.cyc, 2);
                n_out++;
            end
`ifdef CFA_RB_SAT_CNT_EN
            if (sat_clr) begin
                m_lo = 0;
                m_hi = 0;
            end else begin
                m_lo = (m_lo + e.nlo > 65535) ? 65535 : m_lo + e.nlo;
                m_hi = (m_hi + e.nhi > 65535) ? 65535 : m_hi + e.nhi;
            end
`endif
            stalled   = out_valid && !out_ready;
            hold_r    = out_r;
            hold_b    = out_b;
            hold_g    = out_g;
            hold_last = out_last;
            if (in_valid && in_ready) begin
                e.nlo = 0;
                e.nhi = 0;
                for (int l = 0; l < L; l++) begin
                    g  = int'(in_g[l*PW +: PW]);
                    vr = g - int'($signed(in_gmr[l*DW +: DW]));
                    vb = g - int'($signed(in_gmb[l*DW +: DW]));
                    e.nlo += int'(vr < 0) + int'(vb < 0);
                    e.nhi += int'(vr > PMAX) + int'(vb > PMAX);
                    e.r[l*PW +: PW] = PW'(clampv(vr));
                    e.b[l*PW +: PW] = PW'(clampv(vb));
                end
                e.g    = in_g;
                e.last = in_last;
                e.cyc  = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input int g, input int gmr, input int gmb);
        in_g[l*PW +: PW]   = PW'(g);
        in_gmr[l*DW +: DW] = DW'(gmr);
        in_gmb[l*DW +: DW] = DW'(gmb);
    endtask

    task automatic rand_lanes();
        for (int l = 0; l < L; l++)
            set_lane(l, int'($urandom_range(0, PMAX)), int'($urandom_range(0, 1023)) - 512,
                     int'($urandom_range(0, 1023)) - 512);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int sent, out0;
        bit acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b0;
        in_g = '0; in_gmr = '0; in_gmb = '0;
`ifdef CFA_RB_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_r", out_r, 0);
        check_eq("rst_out_b", out_b, 0);
        check_eq("rst_out_g", out_g, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        lat_chk = 1'b1;

        // Nominal subtract.
        set_lane(0, 2000, 100, -300); set_lane(1, 1000, 0, 0);
        in_valid = 1'b1; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        step();
        check_eq("nom_valid", out_valid, 1);
        check_eq("nom_r0", out_r[PW-1:0], 1900);
        check_eq("nom_b0", out_b[PW-1:0], 2300);
        check_eq("nom_g0", out_g[PW-1:0], 2000);
        check_eq("nom_b1", out_b[2*PW-1:PW], 1000);
        check_eq("nom_last", out_last, 1);
        step();

        // Low clamp.
        set_lane(0, 50, 200, 0); set_lane(1, 1000, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("lo_r0", out_r[PW-1:0], 0);
        check_eq("lo_b0", out_b[PW-1:0], 50);
        step();
`ifdef CFA_RB_SAT_CNT_EN
        check_eq("lo_cnt_inc", sat_lo_cnt, 1);
`endif

        // High clamp, neighbouring lane unaffected.
        set_lane(0, 4000, 0, -512); set_lane(1, 10, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("hi_b0", out_b[PW-1:0], 4095);
        check_eq("hi_r0", out_r[PW-1:0], 4000);
        check_eq("hi_b1", out_b[2*PW-1:PW], 10);
        step();
`ifdef CFA_RB_SAT_CNT_EN
        check_eq("hi_cnt_inc", sat_hi_cnt, 1);
`endif

        // Backpressure: 10 incrementing beats, out_ready low for cycles 3..7.
        lat_chk = 1'b0; saw_block = 1'b0; out0 = n_out; sent = 0;
        for (int c = 0; c < 60 && sent < 10; c++) begin
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = 1'b1;
            set_lane(0, 100 + sent, sent, -sent);
            set_lane(1, 4000 + 20*sent, -10*sent, 40*sent);
            in_last = (sent == 9);
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        drain();
        check_eq("bp_sent", sent, 10);
        check_eq("bp_out_count", n_out - out0, 10);
        check_eq("bp_in_ready_dropped", saw_block, 1);

        // Bubbles.
        lat_chk = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c % 2 == 0);
            rand_lanes();
            step();
        end
        in_valid = 1'b0;
        drain();

        // Random traffic.
        lat_chk = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_last   = $urandom_range(0, 1);
            rand_lanes();
`ifdef CFA_RB_SAT_CNT_EN
            sat_clr = ($urandom_range(0, 31) == 0);
`endif
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
`ifdef CFA_RB_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        drain();

        // Reset with two beats in flight.
        lat_chk = 1'b1;
        set_lane(0, 50, 200, 0); set_lane(1, 4000, 0, -512);
        in_valid = 1'b1;
        step();
        rand_lanes();
        step();
        in_valid = 1'b0;
        check_eq("pre_rst_valid", out_valid, 1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_lo = 0; m_hi = 0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_r", out_r, 0);
        check_eq("mid_rst_last", out_last, 0);
`ifdef CFA_RB_SAT_CNT_EN
        check_eq("mid_rst_lo_cnt", sat_lo_cnt, 0);
        check_eq("mid_rst_hi_cnt", sat_hi_cnt, 0);
`endif
        step();
        step();
        rst = 1'b0;
        check_eq("post_rst_in_ready", in_ready, 1);
        set_lane(0, 3000, -100, 511); set_lane(1, 0, 1, -1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_r0", out_r[PW-1:0], 3100);
        check_eq("post_rst_b0", out_b[PW-1:0], 2489);
        check_eq("post_rst_r1", out_r[2*PW-1:PW], 0);
        check_eq("post_rst_b1", out_b[2*PW-1:PW], 1);
        drain();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cfa_rb_recon.md
Name: cfa_rb_recon

Overview:
Multi-lane, pipelined colour reconstruction for the CFA demosaic datapath. Per pixel it computes R = clamp(G - (G-R)) and B = clamp(G - (G-B)) from an interpolated G value and two signed colour-difference estimates. It processes LANES pixels per beat, uses valid/ready flow control, and sits between the colour-difference interpolators and the RGB output packer.

Parameters:
PIXEL_W, 12, unsigned pixel width for G, R and B.
DIFF_W, 10, width of each signed two's-complement colour difference; must be at most PIXEL_W.
LANES, 2, pixels per beat.
CNT_W, 16, width of the saturation counters (used only when the optional feature is built).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_g  in  LANES*PIXEL_W  G per lane; lane 0 in the LSBs
in_gmr  in  LANES*DIFF_W  signed G-R per lane
in_gmb  in  LANES*DIFF_W  signed G-B per lane
in_last  in  1  end-of-line sideband, passed through unchanged
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_r  out  LANES*PIXEL_W  reconstructed R
out_b  out  LANES*PIXEL_W  reconstructed B
out_g  out  LANES*PIXEL_W  G, delay-matched to R and B
out_last  out  1  delay-matched in_last

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all stage valids 0, so out_valid = 0. out_r, out_b, out_g and out_last are 0. in_ready is 1 after reset.
- Pipeline: two register stages, S1 and S2.
  - S1 captures the inputs and forms per-lane differences at PIXEL_W+2 bits: {2'b00, g} minus the sign-extended difference.
  - S2 clamps and registers the result.
  - Latency is exactly 2 cycles from an accepted input to out_valid when out_ready stays high. Throughput is 1 beat per cycle.
- Arithmetic:
  - Negative result: output 0.
  - Result above 2^PIXEL_W-1: output 2^PIXEL_W-1.
  - Otherwise: the low PIXEL_W bits.
  - Negative differences (G below the colour) must not wrap.
- Flow control:
  - Advance enable: en = !out_valid || out_ready. Both stages move only when en = 1.
  - in_ready = en. An input is accepted when in_valid && in_ready.
  - When en = 1 a bubble enters S1 if no input is accepted.
  - While out_valid=1 and out_ready=0, all stage contents and outputs hold stable.
- Simultaneous accept and output in the same cycle is legal and is the steady state.
- Lanes are fully independent; saturation in one lane never affects another.
- Reset asserted mid-stream discards all in-flight beats immediately. out_valid drops asynchronously.

Optional Feature:
- Macro: CFA_RB_SAT_CNT_EN.
- When defined, the block adds these ports:
  - sat_clr (in, 1): synchronous clear.
  - sat_lo_cnt (out, CNT_W): counts lane results clamped to 0.
  - sat_hi_cnt (out, CNT_W): counts lane results clamped to max.
- Counting rules:
  - Counts are taken per S2 beat actually transferred (out_valid && out_ready).
  - Each increment adds the number of R and B lanes that clamped on that beat, from 0 to 2*LANES.
  - Counters saturate at all-ones; they do not wrap.
  - sat_clr wins over a simultaneous increment.
  - Both counters reset to 0 on rst.
- When not defined, those ports and counters do not exist and the datapath is identical.

Decomposition:
- Package cfa_pkg holds:
  - default PIXEL_W and DIFF_W;
  - localparam PIX_MAX = 2^PIXEL_W-1;
  - the lane-slicing index helper.
- Sub-module cfa_sat_sub performs one lane's extended subtract plus clamp and flags lo/hi saturation. It is instantiated 2*LANES times through generate.

Test Plan:
- Nominal subtract, defaults: lane0 G=2000, gmr=100, gmb=-300 -> after 2 cycles R=1900, B=2300, G=2000.
- Low clamp: G=50, gmr=200 -> R=0. With CFA_RB_SAT_CNT_EN, sat_lo_cnt increments by 1.
- High clamp: G=4000, gmb=-512 -> B=4095. Lane1 G=10, gmb=0 in the same beat -> lane1 B=10 (lanes independent).
- Backpressure:
  - Stream 10 incrementing beats while holding out_ready=0 for cycles 3 to 7.
  - in_ready must drop once both stages are full.
  - Outputs must hold stable while stalled.
  - All 10 beats emerge in order with no loss or duplication; out_last stays aligned with its beat.
- Bubbles: toggle in_valid every other cycle with out_ready=1 -> out_valid follows the same pattern delayed by 2 cycles.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 immediately, counters return to 0. After release the first new beat appears 2 cycles after acceptance.
